// File: rtl/sample_packer.sv
// sample_packer: packs SAMPLE_W-bit acquisition samples into LINE_W-bit lines and
// writes completed lines into an input-buffer FIFO through a one-entry pending register.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, stop           one-cycle pulses: arm a capture / end it early
//   capture_len           lines to capture (0 = unlimited), sampled on start
//   s_valid, s_data       sample stream
//   ib_full               input-buffer full flag
//   ib_we, ib_din         registered input-buffer write port
//   busy, done            status: not idle / one-cycle completion pulse
//   line_cnt              lines written in the current capture
//   overflow_cnt          lines dropped in the current capture (saturating)
module sample_packer #(
  parameter int unsigned         SAMPLE_W = 16,
  parameter int unsigned         LINE_W   = 256,
  parameter logic [SAMPLE_W-1:0] PAD      = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [23:0]         capture_len,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                ib_full,
  output logic                ib_we,
  output logic [LINE_W-1:0]   ib_din,
  output logic                busy,
  output logic                done,
  output logic [23:0]         line_cnt,
  output logic [15:0]         overflow_cnt
);

  localparam int unsigned    Slots   = LINE_W / SAMPLE_W;
  localparam int unsigned    IdxW    = (Slots > 1) ? $clog2(Slots) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Slots - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StFlush,
    StDrain,
    StDone
  } state_e;

  state_e              state_q;
  logic [IdxW-1:0]     idx_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   pend_q;
  logic                pend_valid_q;
  logic [23:0]         len_q;
  logic [23:0]         pkt_cnt_q;

  logic                take;
  logic                complete;
  logic                drain;
  logic                pend_free;
  logic                len_hit;
  logic [LINE_W-1:0]   line_ins;
  logic [LINE_W-1:0]   line_pad;
  logic [15:0]         ovf_inc;

  assign busy = (state_q != StIdle);

  always_comb begin
    take      = (state_q == StCapture) && s_valid;
    complete  = take && (idx_q == LastIdx);
    drain     = pend_valid_q && !ib_full;
    // The pending register can accept a line if empty or being emptied this cycle.
    pend_free = !pend_valid_q || drain;
    len_hit   = (len_q != 24'd0) && ((pkt_cnt_q + 24'd1) == len_q);
    ovf_inc   = (overflow_cnt == 16'hFFFF) ? overflow_cnt : overflow_cnt + 16'd1;
    line_ins  = line_q;
    line_pad  = line_q;
    for (int i = 0; i < Slots; i++) begin
      if (IdxW'(i) == idx_q) line_ins[i*SAMPLE_W +: SAMPLE_W] = s_data;
      if (IdxW'(i) >= idx_q) line_pad[i*SAMPLE_W +: SAMPLE_W] = PAD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      line_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      len_q        <= '0;
      pkt_cnt_q    <= '0;
      ib_we        <= 1'b0;
      ib_din       <= '0;
      done         <= 1'b0;
      line_cnt     <= '0;
      overflow_cnt <= '0;
    end else begin
      ib_we <= 1'b0;
      done  <= 1'b0;

      if (drain) begin
        ib_we        <= 1'b1;
        ib_din       <= pend_q;
        pend_valid_q <= 1'b0;
        line_cnt     <= line_cnt + 24'd1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q        <= capture_len;
            idx_q        <= '0;
            line_cnt     <= '0;
            overflow_cnt <= '0;
            pkt_cnt_q    <= '0;
            state_q      <= StCapture;
          end
        end

        StCapture: begin
          if (take) begin
            line_q <= line_ins;
            idx_q  <= complete ? '0 : idx_q + IdxW'(1);
          end
          if (complete) begin
            pkt_cnt_q <= pkt_cnt_q + 24'd1;
            if (pend_free) begin
              pend_q       <= line_ins;
              pend_valid_q <= 1'b1;
            end else begin
              overflow_cnt <= ovf_inc;
            end
            if (stop || len_hit) state_q <= StDrain;
          end else if (stop) begin
            // A sample taken alongside stop still counts toward the partial line.
            state_q <= (take || idx_q != '0) ? StFlush : StDrain;
          end
        end

        StFlush: begin
          if (pend_free) begin
            pend_q       <= line_pad;
            pend_valid_q <= 1'b1;
            idx_q        <= '0;
            state_q      <= StDrain;
          end
        end

        StDrain: begin
          // Any write issued from the last pending line is on the bus this cycle.
          if (!pend_valid_q) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed scenarios plus randomized captures,
// compared every cycle against a transaction-level reference model.
module tb_sample_packer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, stop, s_valid, ib_full;
  logic [23:0]  capture_len;
  logic [15:0]  s_data;
  logic         ib_we, busy, done;
  logic [255:0] ib_din;
  logic [23:0]  line_cnt;
  logic [15:0]  overflow_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  always #5 clk = ~clk;

  sample_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .capture_len  (capture_len),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .ib_full      (ib_full),
    .ib_we        (ib_we),
    .ib_din       (ib_din),
    .busy         (busy),
    .done         (done),
    .line_cnt     (line_cnt),
    .overflow_cnt (overflow_cnt)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 capturing, 2 flushing partial line, 3 draining, 4 done
  int           m_phase;
  logic [15:0]  m_cur[$];
  logic         m_pend;
  logic [255:0] m_pend_line;
  int           m_len, m_pkt;
  logic         e_we, e_done;
  logic [255:0] e_din;
  int           e_lines, e_ovf;

  // Observed writes (for directed checks)
  logic [255:0] wr_data[$];
  int           wr_cyc[$];
  int           done_cyc;

  function automatic logic [255:0] pack(input logic [15:0] q[$]);
    logic [255:0] l = '0;
    for (int i = 0; i < 16; i++) l[i*16 +: 16] = (i < q.size()) ? q[i] : 16'h0000;
    return l;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cur.delete(); m_pend = 0; m_pend_line = '0;
    m_len = 0; m_pkt = 0; e_we = 0; e_done = 0; e_din = '0; e_lines = 0; e_ovf = 0;
  endtask

  task automatic model_step(input logic st, input logic sp, input int len, input logic sv,
                            input logic [15:0] sd, input logic full);
    logic was_pend = m_pend;
    e_we = 0; e_done = 0;
    if (m_pend && !full) begin
      e_we = 1; e_din = m_pend_line; m_pend = 0; e_lines++;
    end
    case (m_phase)
      0: if (st) begin
        m_len = len; m_cur.delete(); e_lines = 0; e_ovf = 0; m_pkt = 0; m_phase = 1;
      end
      1: begin
        if (sv) begin
          m_cur.push_back(sd);
          if (m_cur.size() == 16) begin
            logic [255:0] l = pack(m_cur);
            m_cur.delete();
            m_pkt++;
            if (!m_pend) begin m_pend = 1; m_pend_line = l; end
            else if (e_ovf < 65535) e_ovf++;
            if (sp || (m_len != 0 && m_pkt == m_len)) m_phase = 3;
          end else if (sp) m_phase = 2;
        end else if (sp) m_phase = (m_cur.size() == 0) ? 3 : 2;
      end
      2: if (!m_pend) begin
        m_pend = 1; m_pend_line = pack(m_cur); m_cur.delete(); m_phase = 3;
      end
      3: if (!was_pend) begin m_phase = 4; e_done = 1; end
      default: m_phase = 0;
    endcase
  endtask

  // One clock: drive inputs at negedge, compare outputs at the following negedge.
  task automatic cyc(input logic st, input logic sp, input int len, input logic sv,
                     input logic [15:0] sd, input logic full);
    start = st; stop = sp; capture_len = 24'(len); s_valid = sv; s_data = sd; ib_full = full;
    model_step(st, sp, len, sv, sd, full);
    @(negedge clk);
    cyc_n++;
    check("ib_we", 256'(ib_we), 256'(e_we));
    if (e_we) check("ib_din", ib_din, e_din);
    check("busy", 256'(busy), 256'(m_phase != 0));
    check("done", 256'(done), 256'(e_done));
    check("line_cnt", 256'(line_cnt), 256'(e_lines));
    check("overflow_cnt", 256'(overflow_cnt), 256'(e_ovf));
    if (ib_we) begin wr_data.push_back(ib_din); wr_cyc.push_back(cyc_n + 1); end
    if (done) done_cyc = cyc_n + 1;
  endtask

  task automatic idle_until_done(input logic full, input int budget);
    int k = 0;
    while (m_phase != 0 && k < budget) begin cyc(0, 0, 0, 0, 16'h0, full); k++; end
    if (m_phase != 0) check("done_timeout", 256'(0), 256'(1));
  endtask

  task automatic clear_log();
    wr_data.delete(); wr_cyc.delete(); done_cyc = -1;
  endtask

  initial begin
    int n16;
    reset_n = 0; start = 0; stop = 0; capture_len = '0; s_valid = 0; s_data = '0; ib_full = 0;
    model_reset();
    #1;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_ib_we", 256'(ib_we), 256'(0));
    check("rst_ib_din", ib_din, 256'(0));
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Two-line capture of an incrementing ramp
    clear_log();
    cyc(1, 0, 2, 0, 16'h0, 0);
    n16 = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 1, 16'(i), 0);
      if (i == 15) n16 = cyc_n;
    end
    idle_until_done(0, 20);
    check("t1_writes", 256'(wr_data.size()), 256'(2));
    if (wr_data.size() == 2) begin
      check("t1_slot0", 256'(wr_data[0][15:0]), 256'(16'h0000));
      check("t1_slot15", 256'(wr_data[0][255:240]), 256'(16'h000F));
      check("t1_latency", 256'(wr_cyc[0]), 256'(n16 + 2));
      check("t1_done_cyc", 256'(done_cyc), 256'(wr_cyc[1] + 1));
    end
    check("t1_line_cnt", 256'(line_cnt), 256'(2));
    check("t1_ovf", 256'(overflow_cnt), 256'(0));

    // Partial line flushed by stop
    clear_log();
    cyc(1, 0, 0, 0, 16'h0, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 1, 16'hA000 + 16'(i), 0);
    cyc(0, 1, 0, 0, 16'h0, 0);
    idle_until_done(0, 20);
    check("t2_writes", 256'(wr_data.size()), 256'(1));
    if (wr_data.size() == 1)
      check("t2_line", wr_data[0], {176'h0, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001});
    check("t2_done_seen", 256'(done_cyc > 0), 256'(1));

    // Input buffer full during three lines
    clear_log();
    cyc(1, 0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 48; i++) cyc(0, 0, 0, 1, 16'h3000 + 16'(i), 1);
    check("t3_no_write", 256'(wr_data.size()), 256'(0));
    check("t3_ovf", 256'(overflow_cnt), 256'(2));
    repeat (4) cyc(0, 0, 0, 0, 16'h0, 0);
    cyc(0, 1, 0, 0, 16'h0, 0);
    idle_until_done(0, 20);
    check("t3_writes", 256'(wr_data.size()), 256'(1));
    if (wr_data.size() == 1)
      check("t3_line0", 256'(wr_data[0][255:240]), 256'(16'h300F));
    check("t3_line_cnt", 256'(line_cnt), 256'(1));

    // Reset in the middle of a capture with a pending line and 7 slots filled
    clear_log();
    cyc(1, 0, 0, 0, 16'h0, 1);
    for (int i = 0; i < 23; i++) cyc(0, 0, 0, 1, 16'h5000 + 16'(i), 1);
    #2 reset_n = 0;
    #1;
    check("t4_busy", 256'(busy), 256'(0));
    check("t4_ib_we", 256'(ib_we), 256'(0));
    check("t4_done", 256'(done), 256'(0));
    check("t4_line_cnt", 256'(line_cnt), 256'(0));
    check("t4_ovf", 256'(overflow_cnt), 256'(0));
    check("t4_ib_din", ib_din, 256'(0));
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 40; i++) cyc(0, 1'($urandom_range(0, 1)), 0, 1, 16'($urandom), 0);
    check("t4_no_write", 256'(wr_data.size()), 256'(0));

    // Randomized captures
    for (int t = 0; t < 12; t++) begin
      int len   = $urandom_range(0, 3);
      int fmode = t % 3;
      int k     = 0;
      for (int i = 0; i < 5; i++)
        cyc(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 16'($urandom), 0);
      cyc(1, 0, len, 0, 16'h0, 0);
      while (m_phase != 0 && k < 1500) begin
        logic sv   = ($urandom % 4) != 0;
        logic full = (fmode == 0) ? 1'b0 : (fmode == 1) ? (($urandom % 4) == 0)
                                                        : (($urandom % 4) != 0);
        logic sp   = !sv && ((($urandom % 60) == 0) || k > 500);
        logic st   = ($urandom % 50) == 0;
        cyc(st, sp, $urandom_range(0, 3), sv, 16'($urandom), full);
        k++;
      end
      if (m_phase != 0) check("rand_timeout", 256'(0), 256'(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter SAMPLE_W, default 16, width of one acquisition sample in bits.
REQ-002 Parameter LINE_W, default 256, width of one packed line; it SHALL equal the input-buffer word width; LINE_W/SAMPLE_W = 16 slots.
REQ-003 Parameter PAD, default 16'h0000, fill value for unused slots of a flushed partial line.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle pulse that arms a capture.
REQ-007 stop  in  1  one-cycle pulse that ends a capture early.
REQ-008 capture_len  in  24  lines to capture; 0 = unlimited; sampled on start.
REQ-009 s_valid  in  1  s_data holds a valid sample this cycle.
REQ-010 s_data  in  SAMPLE_W  sample value.
REQ-011 ib_full  in  1  input-buffer FIFO full flag.
REQ-012 ib_we  out  1  input-buffer write enable, registered.
REQ-013 ib_din  out  LINE_W  input-buffer write data, registered.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at capture completion.
REQ-016 line_cnt  out  24  lines written to the input buffer in the current capture.
REQ-017 overflow_cnt  out  16  lines dropped in the current capture, saturating at 16'hFFFF.

Function
REQ-018 States SHALL be IDLE, CAPTURE, FLUSH, DRAIN, DONE.
REQ-019 IDLE: start -> CAPTURE; latch capture_len, clear slot index, line_cnt, overflow_cnt, packed-line counter; stop and s_valid ignored.
REQ-020 CAPTURE: each s_valid stores s_data into slot[idx] (slot 0 = bits [15:0], slot 15 = bits [255:240]) and increments the 4-bit idx, wrapping 15 -> 0.
REQ-021 A sample into slot 15 SHALL complete a line; the complete line moves to a one-entry pending register (pend_valid set next cycle) and the packed-line counter increments.
REQ-022 Pending drain: when pend_valid=1 and ib_full=0, next cycle ib_we=1, ib_din=pending, pend_valid cleared, line_cnt+1; ib_we SHALL never assert for a cycle whose ib_full sample was 1.
REQ-023 Latency: 16th sample in cycle N -> ib_we=1 in cycle N+2 when ib_full=0.
REQ-024 Line completes while pend_valid=1 and pending is not draining that same cycle: new line dropped, overflow_cnt+1 (saturating); pending retained; packed-line counter still increments.
REQ-025 Line completes in the same cycle pending drains: new line loads pending, no drop.
REQ-026 capture_len!=0 and packed-line counter reaches capture_len: CAPTURE -> DRAIN; further samples ignored.
REQ-027 stop in CAPTURE with idx=0 -> DRAIN; with idx!=0 -> FLUSH.
REQ-028 stop together with the slot-15 sample: sample stored, line completes, -> DRAIN.
REQ-029 FLUSH: samples ignored; slots idx..15 filled with PAD; when pending is free or draining this cycle, partial line loads pending, idx=0, -> DRAIN; otherwise wait (no drop).
REQ-030 DRAIN: when pend_valid=0 and no write outstanding -> DONE.
REQ-031 DONE: done=1 for exactly one cycle -> IDLE; line_cnt and overflow_cnt hold until next start.
REQ-032 start outside IDLE SHALL be ignored.

Reset
REQ-033 reset_n=0 SHALL asynchronously force state IDLE, idx=0, pend_valid=0, ib_we=0, ib_din=0, busy=0, done=0, line_cnt=0, overflow_cnt=0.
REQ-034 Reset mid-capture SHALL discard any partial and pending line without a write; first activity after release requires a new start.

Verification
REQ-035 start, capture_len=2, 32 consecutive samples 0x0000..0x001F, ib_full=0 -> two writes, first ib_din[15:0]=0x0000, [255:240]=0x000F; line_cnt=2; done one cycle after last write; overflow_cnt=0.
REQ-036 capture_len=0, 5 samples 0xA001..0xA005, then stop -> one write, slots 0-4 = samples, slots 5-15 = 0x0000; done pulses.
REQ-037 ib_full=1 held while 48 samples arrive -> no ib_we; overflow_cnt=2; release ib_full -> exactly one write of line 0, line_cnt=1.
REQ-038 16th sample at cycle N with ib_full=0 -> ib_we=1 exactly in cycle N+2.
REQ-039 reset_n low during CAPTURE with idx=7 and pend_valid=1 -> all outputs at reset values immediately; no write after release; s_valid ignored until start.
